// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, checks alignment/bounds, buffers words for decode.
// Latency 1 cycle fetch-to-out_valid; stalls when the buffer is full and not popping. Optional FETCH_PERF_EN adds counters.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_0000_0000,
    parameter int          MEM_WORDS  = 2048,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        out_exc_en,
    output logic [3:0]  out_exc_code,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic [63:0] out_exc_val
);

    localparam int          PTR_W       = $clog2(FIFO_DEPTH);
    localparam int          CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP         = 32'h0000_0013;
    localparam logic [61:0] MEM_WORDS_W = 62'(MEM_WORDS);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } fentry_t;

    state_t           state_q;
    logic [63:0]      pc_q;
    logic [63:0]      pc_d;
    fentry_t          fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W-1:0] wr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic    pop;
    logic    push_ok;
    logic    push;
    logic    misalign;
    logic    fault;
    fentry_t new_entry;
    fentry_t head;

    assign imem_addr = pc_q;

    always_comb begin
        pop      = (count_q != '0) & out_ready;
        push_ok  = (count_q < DEPTH_C) | pop;
        push     = (state_q == RUN) & push_ok & ~redirect_valid;
        misalign = (pc_q[1:0] != 2'b00);
        fault    = (pc_q[63:2] >= MEM_WORDS_W);

        // Misalignment wins over the bounds check; faults carry a NOP so decode sees a benign word.
        new_entry = '{instr: imem_rdata, pc: pc_q, exc_en: 1'b0, exc_code: 4'd0, exc_val: 64'd0};
        pc_d      = pc_q + 64'd4;
        if (misalign) begin
            new_entry = '{instr: NOP, pc: pc_q, exc_en: 1'b1, exc_code: 4'd0, exc_val: pc_q};
            pc_d      = pc_q;
        end else if (fault) begin
            new_entry = '{instr: NOP, pc: pc_q, exc_en: 1'b1, exc_code: 4'd1, exc_val: pc_q};
            pc_d      = pc_q;
        end

        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (redirect_valid) begin
            // Any same-cycle pop still completes for decode; its entry is discarded with the rest.
            state_q <= RUN;
            pc_q    <= redirect_pc;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (pop)
                rd_q <= rd_q + PTR_W'(1);
            if (push) begin
                fifo_q[wr_q] <= new_entry;
                wr_q         <= wr_q + PTR_W'(1);
            end
            case (state_q)
                RUN: begin
                    if (push) begin
                        pc_q <= pc_d;
                        if (misalign || fault)
                            state_q <= HALT;
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push && !misalign && !fault)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if ((state_q == RUN) && !push_ok && !redirect_valid)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

    // Empty buffer presents the reset-value head rather than stale storage.
    always_comb begin
        head         = fifo_q[rd_q];
        out_valid    = (count_q != '0);
        out_instr    = out_valid ? head.instr    : NOP;
        out_pc       = out_valid ? head.pc       : 64'd0;
        out_exc_en   = out_valid ? head.exc_en   : 1'b0;
        out_exc_code = out_valid ? head.exc_code : 4'd0;
        out_exc_val  = out_valid ? head.exc_val  : 64'd0;
    end

endmodule
